rtm_rd_arb: RTL and testbench
=============================

// Module: rtm_rd_arb
// PURPOSE
//  Round-robin, burst-locking arbiter that shares the single RTM read port between NUM_REQ
//  clients (DRAM writer, X-bus, Fc, Add, Remap).
//  Replaces fixed-priority selection: a burst keeps the port from its first beat to its last.
//  Issues registered rd_en/rd_addr to the RTM and routes returned data back with per-client valid/last.
// PARAMETERS
//  NUM_REQ   5   number of read clients; index 0 = DRAM ... 4 = Remap
//  S         8   RTM slices; width of per-beat slice enable
//  ADDR_W    12  per-slice address width, $clog2(RTM_DEPTH)
//  DW        512 RTM read data width, S*R*8
//  RD_LAT    5   accept-to-dout_vld latency, RTM_URAM_NUM_PIPE+3; must be >= 3
// PORTS
//  clk        in   1               clock
//  rstn       in   1               synchronous reset, active low
//  req_vld    in   NUM_REQ         per-client beat valid
//  req_last   in   NUM_REQ         beat is the last of the client's burst
//  req_en     in   NUM_REQ*S       per-client slice enables, client i at [i*S +: S]
//  req_addr   in   NUM_REQ*S*ADDR_W  per-client slice addresses, packed the same way
//  req_rdy    out  NUM_REQ         beat accepted this cycle (combinational)
//  rd_en      out  S               RTM read enable (registered)
//  rd_addr    out  S*ADDR_W        RTM read address (registered)
//  dout       in   DW              RTM read data
//  rsp_data   out  DW              registered copy of dout, shared by all clients
//  rsp_vld    out  NUM_REQ         one-hot: rsp_data belongs to client i
//  rsp_last   out  NUM_REQ         returned beat was a last beat
//  busy       out  1               a burst currently owns the port
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - state=IDLE, rr_ptr=0, rd_en=0, rd_addr=0, rsp_data=0, rsp_vld=0, rsp_last=0, busy=0.
//   - All tag-pipeline valids are cleared; req_rdy is forced 0 while rstn=0.
//  Accept: beat of client i accepted in cycle T iff req_vld[i] && req_rdy[i]. At most one req_rdy bit is high.
//  IDLE state:
//   - Winner = first i with req_vld[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - req_rdy[winner]=1, so the first beat is accepted in the same cycle.
//   - If that beat has req_last, stay IDLE and set rr_ptr=winner+1 (mod NUM_REQ).
//   - Otherwise go to BUSY with owner=winner; busy=1 from T+1.
//  BUSY state:
//   - req_rdy = req_vld[owner] on bit owner only; other clients stall regardless of their req_vld.
//   - Owner bubbles (req_vld[owner]=0) are allowed; no RTM read is issued and the lock is kept.
//   - An accepted beat with req_last returns to IDLE and sets rr_ptr=owner+1.
//   - Arbitration in the cycle after a last beat follows the IDLE rules with the new rr_ptr.
//  RTM issue, at T+1 for a beat accepted at T:
//   - rd_en <= req_en[owner]; rd_addr <= req_addr[owner].
//   - If no beat is accepted: rd_en <= 0 and rd_addr holds its value.
//  Return path:
//   - A tag {vld, last, id} enters a shift register at T; rsp_data <= dout every cycle.
//   - At T+RD_LAT: rsp_vld[id]=1, rsp_last[id]=req_last of that beat, and rsp_data holds that beat's data.
//   - Back-to-back accepts return back-to-back in issue order; no reordering and no backpressure on responses.
//  Width/wrap: rr_ptr is $clog2(NUM_REQ) bits and wraps NUM_REQ-1 -> 0 explicitly, not by overflow.
//  Boundary cases:
//   - Single-beat bursts never enter BUSY.
//   - All clients requesting: grant order is strictly rotating.
//   - Reset mid-burst drops ownership; all in-flight responses are discarded with no rsp_vld.
//   - A client that never sends last starves the others; this is an accepted protocol requirement on clients.
// TESTING
//  1. Reset: rstn=0 for 3 cycles while all req_vld=1.
//     -> req_rdy=0, rd_en=0, rsp_vld=0; the first grant after release goes to client 0.
//  2. Client 2 sends 4 beats (addr 10..13, last on beat 4) while client 0 requests continuously.
//     -> req_rdy[0]=0 for all 4 beats; client 0 is granted the cycle after beat 4.
//     -> rsp_vld[2] is high at T+5..T+8 with rsp_last[2] on the 4th.
//  3. All 5 clients send single-beat bursts continuously.
//     -> Grant order is 0,1,2,3,4,0,...; one grant per cycle; rd_en is never 0 between grants.
//  4. Client 3 bursts 3 beats with a 2-cycle bubble after beat 1 while client 1 requests.
//     -> rd_en=0 for 2 cycles; client 1 stays stalled until client 3's last beat.
//  5. rstn pulsed low at the 2nd of 4 beats in flight.
//     -> No rsp_vld afterwards; busy=0; the next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/rtm_rd_arb.sv
// rtm_rd_arb -- round-robin, burst-locking arbiter for the single RTM read port.
//
// Shares the RTM read port between NUM_REQ clients (0 = DRAM writer, 1 = X-bus,
// 2 = Fc, 3 = Add, 4 = Remap). Once a client's first beat is accepted, the port
// stays locked to it until its last beat. Reads are issued with registered
// rd_en/rd_addr. A tag pipeline routes the returned data back to the issuing
// client, in issue order, RD_LAT cycles after acceptance.
//
// Ports
//   clk, rstn   clock, synchronous active-low reset
//   req_vld     per-client beat valid
//   req_last    per-client "this beat ends the burst"
//   req_en      per-client slice enables, client i at [i*S +: S]
//   req_addr    per-client slice addresses, client i at [i*S*ADDR_W +: S*ADDR_W]
//   req_rdy     combinational accept strobe, at most one bit set
//   rd_en       registered RTM slice read enable
//   rd_addr     registered RTM slice read address (holds when idle)
//   dout        RTM read data
//   rsp_data    registered copy of dout, shared by all clients
//   rsp_vld     one-hot owner of rsp_data
//   rsp_last    returned beat was the last of its burst
//   busy        a multi-beat burst currently owns the port
module rtm_rd_arb #(
   parameter int unsigned NUM_REQ = 5,
   parameter int unsigned S       = 8,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DW      = 512,
   parameter int unsigned RD_LAT  = 5
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_vld,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*S-1:0]          req_en,
   input  logic [NUM_REQ*S*ADDR_W-1:0]   req_addr,
   output logic [NUM_REQ-1:0]            req_rdy,
   output logic [S-1:0]                  rd_en,
   output logic [S*ADDR_W-1:0]           rd_addr,
   input  logic [DW-1:0]                 dout,
   output logic [DW-1:0]                 rsp_data,
   output logic [NUM_REQ-1:0]            rsp_vld,
   output logic [NUM_REQ-1:0]            rsp_last,
   output logic                          busy
);

   localparam int unsigned PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // The tag spends RD_LAT-1 cycles in the shift register; the response
   // register adds the final cycle. RD_LAT >= 3 keeps at least two stages.
   localparam int unsigned TD       = RD_LAT - 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   sel_idx;
   logic            sel_vld;
   logic            accept;
   logic            acc_last;
   logic [S-1:0]    sel_en;
   logic [S*ADDR_W-1:0] sel_addr;

   logic [S-1:0]        rd_en_q;
   logic [S*ADDR_W-1:0] rd_addr_q;

   logic [TD-1:0]   tag_vld_q;
   logic [TD-1:0]   tag_last_q;
   logic [PW-1:0]   tag_id_q [TD];

   logic [DW-1:0]       rsp_data_q;
   logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
   logic [NUM_REQ-1:0]  rsp_last_q, rsp_last_d;

   // Pointer increment with an explicit wrap at NUM_REQ-1.
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
      return (x == LAST_IDX) ? '0 : x + PW'(1);
   endfunction

   // Client index k positions after base, modulo NUM_REQ (base < NUM_REQ).
   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
      int unsigned t;
      t = 32'(base) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      return PW'(t);
   endfunction

   // Round-robin search starting at rr_ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!win_found && req_vld[rr_idx(rr_ptr_q, k)]) begin
            win_found = 1'b1;
            win_idx   = rr_idx(rr_ptr_q, k);
         end
      end
   end

   // While locked, only the owner is considered; its bubbles grant nothing.
   always_comb begin
      if (state_q == BUSY) begin
         sel_idx = owner_q;
         sel_vld = req_vld[owner_q];
      end else begin
         sel_idx = win_idx;
         sel_vld = win_found;
      end
   end

   assign accept   = rstn & sel_vld;
   assign acc_last = req_last[sel_idx];

   // Mux the selected client's slice enables and addresses.
   always_comb begin
      sel_en   = '0;
      sel_addr = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (sel_idx == PW'(k)) begin
            sel_en   = req_en[k*S +: S];
            sel_addr = req_addr[k*S*ADDR_W +: S*ADDR_W];
         end
      end
   end

   // FSM: state register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // FSM: next state. A single-beat burst is granted and released in IDLE.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (acc_last) begin
                  rr_ptr_d = wrap_inc(sel_idx);
               end else begin
                  state_d = BUSY;
                  owner_d = sel_idx;
               end
            end
         end
         BUSY: begin
            if (accept && acc_last) begin
               state_d  = IDLE;
               rr_ptr_d = wrap_inc(owner_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs.
   always_comb begin
      req_rdy = '0;
      if (accept) req_rdy[sel_idx] = 1'b1;
   end

   assign busy = (state_q == BUSY);

   // RTM issue: enable only on an accepted beat, address holds otherwise.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_en_q   <= '0;
         rd_addr_q <= '0;
      end else begin
         rd_en_q <= accept ? sel_en : '0;
         if (accept) rd_addr_q <= sel_addr;
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;

   // Return-path tag pipeline; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         for (int unsigned k = 0; k < TD; k++) tag_id_q[k] <= '0;
      end else begin
         tag_vld_q  <= {tag_vld_q[TD-2:0], accept};
         tag_last_q <= {tag_last_q[TD-2:0], acc_last};
         tag_id_q[0] <= sel_idx;
         for (int unsigned k = 1; k < TD; k++) tag_id_q[k] <= tag_id_q[k-1];
      end
   end

   always_comb begin
      rsp_vld_d  = '0;
      rsp_last_d = '0;
      if (tag_vld_q[TD-1]) begin
         rsp_vld_d[tag_id_q[TD-1]]  = 1'b1;
         rsp_last_d[tag_id_q[TD-1]] = tag_last_q[TD-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rsp_data_q <= '0;
         rsp_vld_q  <= '0;
         rsp_last_q <= '0;
      end else begin
         rsp_data_q <= dout;
         rsp_vld_q  <= rsp_vld_d;
         rsp_last_q <= rsp_last_d;
      end
   end

   assign rsp_data = rsp_data_q;
   assign rsp_vld  = rsp_vld_q;
   assign rsp_last = rsp_last_q;

endmodule

// File: tb/tb_rtm_rd_arb.sv
// Testbench for rtm_rd_arb: per-client beat queues drive the requests, a small
// arbitration model predicts grants, a scoreboard holds expected responses, and
// an RTM model produces address-dependent read data.
module tb_rtm_rd_arb;

   localparam int NR = 5;
   localparam int S  = 8;
   localparam int AW = 12;
   localparam int DW = 512;
   localparam int RL = 5;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [NR-1:0]        req_vld, req_last, req_rdy;
   logic [NR*S-1:0]      req_en;
   logic [NR*S*AW-1:0]   req_addr;
   logic [S-1:0]         rd_en;
   logic [S*AW-1:0]      rd_addr;
   logic [DW-1:0]        dout, rsp_data;
   logic [NR-1:0]        rsp_vld, rsp_last;
   logic                 busy;

   always #5 clk = ~clk;

   rtm_rd_arb #(
      .NUM_REQ (NR),
      .S       (S),
      .ADDR_W  (AW),
      .DW      (DW),
      .RD_LAT  (RL)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req_vld  (req_vld),
      .req_last (req_last),
      .req_en   (req_en),
      .req_addr (req_addr),
      .req_rdy  (req_rdy),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .dout     (dout),
      .rsp_data (rsp_data),
      .rsp_vld  (rsp_vld),
      .rsp_last (rsp_last),
      .busy     (busy)
   );

   // RTM model: data for a read appears on dout RD_LAT-2 cycles after rd_en.
   function automatic logic [DW-1:0] rtm_data(input logic [S-1:0] en, input logic [S*AW-1:0] a);
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++)
         r[i*32 +: 32] = (a[31:0] + 32'(i) * 32'h9E37_79B9) ^ {en, a[87:64]};
      return r;
   endfunction

   logic [DW-1:0] dpipe [RL-2];
   always @(posedge clk) begin
      dpipe[0] <= rtm_data(rd_en, rd_addr);
      for (int i = 1; i < RL-2; i++) dpipe[i] <= dpipe[i-1];
   end
   assign dout = dpipe[RL-3];

   typedef struct packed {
      logic            vld;
      logic            last;
      logic [S-1:0]    en;
      logic [S*AW-1:0] addr;
   } beat_t;

   typedef struct packed {
      int           due;
      int           id;
      logic         last;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct packed {
      int cyc;
      int id;
   } gnt_t;

   beat_t bq [NR][$];
   exp_t  sb [$];
   gnt_t  glog [$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   bit              m_known = 1'b0;
   bit              m_busy  = 1'b0;
   int              m_owner = 0;
   int              m_ptr   = 0;
   logic [S-1:0]    exp_rd_en   = '0;
   logic [S*AW-1:0] exp_rd_addr = '0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic int model_pick();
      if (!rstn) return -1;
      if (m_busy) return req_vld[m_owner] ? m_owner : -1;
      for (int k = 0; k < NR; k++)
         if (req_vld[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      return -1;
   endfunction

   function automatic bit any_pending();
      for (int i = 0; i < NR; i++) if (bq[i].size() > 0) return 1'b1;
      return sb.size() > 0;
   endfunction

   task automatic push_burst(input int id, input int n, input int base, input int bub_after, input int bub_len);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.vld  = 1'b1;
         b.last = (k == n-1);
         b.en   = 8'h01 | 8'(1 << ((base + k) % 8));
         for (int s = 0; s < S; s++) b.addr[s*AW +: AW] = AW'(base + k + s*256);
         bq[id].push_back(b);
         if (k + 1 == bub_after) begin
            for (int j = 0; j < bub_len; j++) begin
               b = '0;
               bq[id].push_back(b);
            end
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (bq[i].size() > 0) begin
            req_vld[i]                 = bq[i][0].vld;
            req_last[i]                = bq[i][0].last;
            req_en[i*S +: S]           = bq[i][0].en;
            req_addr[i*S*AW +: S*AW]   = bq[i][0].addr;
         end else begin
            req_vld[i]                 = 1'b0;
            req_last[i]                = 1'b0;
            req_en[i*S +: S]           = '0;
            req_addr[i*S*AW +: S*AW]   = '0;
         end
      end
   endtask

   // One clock cycle: check at negedge, update model/scoreboard, advance, drive.
   task automatic step();
      int            g;
      logic [NR-1:0] hs;
      exp_t          e;
      beat_t         b;
      gnt_t          t;
      @(negedge clk);
      if (m_known) begin
         chk("rd_en", rd_en, exp_rd_en);
         chk("rd_addr", rd_addr, exp_rd_addr);
         chk("busy", busy, m_busy);
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_vld", rsp_vld, onehot(e.id));
            chk("rsp_last", rsp_last, e.last ? onehot(e.id) : '0);
            chk("rsp_data", rsp_data, e.data);
         end else begin
            chk("rsp_idle", rsp_vld, '0);
         end
      end
      g = model_pick();
      chk("req_rdy", req_rdy, (g >= 0) ? onehot(g) : '0);
      hs = req_vld & req_rdy & {NR{rstn}};
      for (int i = 0; i < NR; i++) begin
         if (hs[i]) begin
            t.cyc = cyc;
            t.id  = i;
            glog.push_back(t);
         end
      end
      if (!rstn) begin
         m_busy = 1'b0; m_owner = 0; m_ptr = 0;
         exp_rd_en = '0; exp_rd_addr = '0;
         sb.delete();
         m_known = 1'b1;
      end else if (g >= 0) begin
         b = bq[g][0];
         e.due = cyc + RL; e.id = g; e.last = b.last; e.data = rtm_data(b.en, b.addr);
         sb.push_back(e);
         exp_rd_en = b.en;
         exp_rd_addr = b.addr;
         if (b.last) begin
            m_busy = 1'b0;
            m_ptr  = (g + 1) % NR;
         end else begin
            m_busy  = 1'b1;
            m_owner = g;
         end
      end else begin
         exp_rd_en = '0;
      end
      for (int i = 0; i < NR; i++)
         if (bq[i].size() > 0 && (!bq[i][0].vld || hs[i])) void'(bq[i].pop_front());
      @(posedge clk);
      cyc++;
      #1;
      drive();
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      while (any_pending() && n < max) begin
         step();
         n++;
      end
      chk("drain_in_budget", (n < max), 1'b1);
   endtask

   task automatic chk_gnt(input string tag, input int idx, input int exp_id, input int exp_cyc);
      if (idx < glog.size()) begin
         chk({tag, "_id"}, glog[idx].id, exp_id);
         chk({tag, "_cyc"}, glog[idx].cyc, exp_cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      // 1: reset held 3 cycles with every client requesting.
      rstn = 1'b0;
      for (int i = 0; i < NR; i++) push_burst(i, 1, 20 + i, 0, 0);
      drive();
      for (int k = 0; k < 3; k++) step();
      rstn = 1'b1;
      drive();
      run_idle(100);
      chk("t1_ngrants", glog.size(), NR);
      for (int k = 0; k < NR; k++) chk_gnt("t1_gnt", k, k, 3 + k);

      // 2: client 2 locks a 4-beat burst while client 0 waits.
      push_burst(1, 1, 50, 0, 0);
      drive();
      run_idle(100);
      glog.delete();
      t0 = cyc;
      push_burst(2, 4, 10, 0, 0);
      for (int k = 0; k < 6; k++) push_burst(0, 1, 100 + k, 0, 0);
      drive();
      run_idle(100);
      chk("t2_ngrants", glog.size(), 10);
      for (int k = 0; k < 10; k++) chk_gnt("t2_gnt", k, (k < 4) ? 2 : 0, t0 + k);

      // 3: every client streams single beats; grants must rotate.
      push_burst(4, 1, 150, 0, 0);
      drive();
      run_idle(100);
      glog.delete();
      t0 = cyc;
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < NR; i++) push_burst(i, 1, 200 + r*NR + i, 0, 0);
      drive();
      run_idle(100);
      chk("t3_ngrants", glog.size(), 3*NR);
      for (int k = 0; k < 3*NR; k++) chk_gnt("t3_gnt", k, k % NR, t0 + k);

      // 4: client 3 burst with a 2-cycle bubble; client 1 stays stalled.
      push_burst(2, 1, 250, 0, 0);
      drive();
      run_idle(100);
      glog.delete();
      t0 = cyc;
      push_burst(3, 3, 300, 1, 2);
      push_burst(1, 1, 400, 0, 0);
      push_burst(1, 1, 401, 0, 0);
      drive();
      run_idle(100);
      chk("t4_ngrants", glog.size(), 5);
      chk_gnt("t4_b1", 0, 3, t0);
      chk_gnt("t4_b2", 1, 3, t0 + 3);
      chk_gnt("t4_b3", 2, 3, t0 + 4);
      chk_gnt("t4_c1a", 3, 1, t0 + 5);
      chk_gnt("t4_c1b", 4, 1, t0 + 6);

      // 5: reset pulse at the second beat of a 4-beat burst.
      glog.delete();
      t0 = cyc;
      push_burst(0, 4, 500, 0, 0);
      drive();
      step();
      push_burst(4, 1, 600, 0, 0);
      rstn = 1'b0;
      drive();
      step();
      chk("t5_busy_in_reset", busy, 1'b0);
      rstn = 1'b1;
      drive();
      run_idle(100);
      chk("t5_ngrants", glog.size(), 5);
      chk_gnt("t5_pre", 0, 0, t0);
      for (int k = 1; k < 4; k++) chk_gnt("t5_c0", k, 0, t0 + 1 + k);
      chk_gnt("t5_c4", 4, 4, t0 + 5);
      for (int k = 0; k < RL + 2; k++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
